// File: rtl/sign_mag_decode_pkg.sv
// Shared definitions for the signed-result to sign/magnitude/BCD decoder.
package sign_mag_decode_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CONV = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int NUM_ITER = 8;
    localparam int BCD_W    = 4;
    localparam int DATA_W   = 8;
    localparam int CNT_W    = 4;

    // Magnitude of an 8-bit two's-complement value; -128 wraps to 8'h80 = 128.
    function automatic logic [DATA_W-1:0] abs8(input logic [DATA_W-1:0] d);
        return d[DATA_W-1] ? (~d + DATA_W'(1)) : d;
    endfunction

endpackage

// File: rtl/sign_mag_decode_bcd_add3.sv
// One double-dabble correction cell: digits of 5 or more get +3 before the shift.
module bcd_add3
    import sign_mag_decode_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] adj
);

    // Pre-shift correction so the doubled digit carries into the next decade.
    always_comb begin
        adj = (digit >= BCD_W'(5)) ? digit + BCD_W'(3) : digit;
    end

endmodule

// File: rtl/sign_mag_decode.sv
// Decodes a signed 8-bit result into sign, magnitude and three BCD digits.
// IDLE accepts a result, CONV spends one cycle loading the shifter and then
// eight shift-add-3 iterations, DONE holds the fields until the consumer takes them.
module sign_mag_decode
    import sign_mag_decode_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              In_Valid,
    input  logic [DATA_W-1:0] In_Data,
    output logic              In_Ready,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Neg,
    output logic [DATA_W-1:0] Mag,
    output logic [BCD_W-1:0]  Hund,
    output logic [BCD_W-1:0]  Tens,
    output logic [BCD_W-1:0]  Ones
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_ITER);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  bin;
    logic [BCD_W-1:0]   hund_adj;
    logic [BCD_W-1:0]   tens_adj;
    logic [BCD_W-1:0]   ones_adj;

    bcd_add3 u_add3_hund (.digit(Hund), .adj(hund_adj));
    bcd_add3 u_add3_tens (.digit(Tens), .adj(tens_adj));
    bcd_add3 u_add3_ones (.digit(Ones), .adj(ones_adj));

    // Control FSM with registered handshake outputs and the conversion datapath.
    // cnt==0 in CONV is the load cycle; cnt 1..8 are the shift iterations, so
    // DONE is entered on the 9th edge after accept.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bin       <= '0;
            Neg       <= 1'b0;
            Mag       <= '0;
            Hund      <= '0;
            Tens      <= '0;
            Ones      <= '0;
            In_Ready  <= 1'b0;
            Out_Valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (In_Ready && In_Valid) begin
                        Neg      <= In_Data[DATA_W-1];
                        Mag      <= abs8(In_Data);
                        cnt      <= '0;
                        Hund     <= '0;
                        Tens     <= '0;
                        Ones     <= '0;
                        In_Ready <= 1'b0;
                        state    <= CONV;
                    end else begin
                        In_Ready <= 1'b1;
                    end
                end
                CONV: begin
                    if (cnt == '0) begin
                        bin <= Mag;
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        // Correct every digit, then shift the next magnitude bit in (MSB first).
                        {Hund, Tens, Ones, bin} <= {hund_adj, tens_adj, ones_adj, bin} << 1;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_ITER) begin
                            state     <= DONE;
                            Out_Valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        In_Ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    // Unused encoding: fall back to IDLE; In_Ready rises on the following edge.
                    state     <= IDLE;
                    In_Ready  <= 1'b0;
                    Out_Valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sign_mag_decode.sv
// Self-checking bench: a cycle-count behavioural model plus directed vectors.
module tb_sign_mag_decode;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       In_Valid = 1'b0;
    logic [7:0] In_Data = 8'h00;
    logic       Out_Ready = 1'b0;
    logic       In_Ready;
    logic       Out_Valid;
    logic       Neg;
    logic [7:0] Mag;
    logic [3:0] Hund;
    logic [3:0] Tens;
    logic [3:0] Ones;

    sign_mag_decode dut (
        .Clk(Clk), .Rst(Rst),
        .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(In_Ready),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Neg(Neg), .Mag(Mag), .Hund(Hund), .Tens(Tens), .Ones(Ones)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks readiness, the 9-cycle latency and the decoded value.
    bit m_on = 0, m_ready = 0, m_valid = 0, m_busy = 0, m_zero = 1;
    int m_cnt = 0, m_neg = 0, m_mag = 0, m_v = 0;

    always @(posedge Clk) begin
        if (Rst) begin
            m_on = 1; m_ready = 0; m_valid = 0; m_busy = 0; m_zero = 1;
            m_neg = 0; m_mag = 0; m_cnt = 0;
        end else if (m_on) begin
            if (m_valid) begin
                if (Out_Ready) begin m_valid = 0; m_ready = 1; end
            end else if (m_busy) begin
                m_cnt++;
                if (m_cnt == 9) begin m_valid = 1; m_busy = 0; end
            end else if (m_ready && In_Valid) begin
                m_v    = int'($signed(In_Data));
                m_neg  = (m_v < 0) ? 1 : 0;
                m_mag  = (m_v < 0) ? -m_v : m_v;
                m_zero = 0; m_ready = 0; m_busy = 1; m_cnt = 0;
            end else begin
                m_ready = 1;
            end
        end
    end

    // Compare process: every cycle once reset has been seen.
    always @(negedge Clk) begin
        if (m_on) begin
            check("in_ready", In_Ready, m_ready);
            check("out_valid", Out_Valid, m_valid);
            check("not_both", In_Ready & Out_Valid, 0);
            check("neg", Neg, m_neg);
            check("mag", Mag, m_mag);
            check("hund_range", int'(Hund <= 4'd1), 1);
            check("tens_range", int'(Tens <= 4'd9), 1);
            check("ones_range", int'(Ones <= 4'd9), 1);
            if (m_zero) begin
                check("hund_zero", Hund, 0);
                check("tens_zero", Tens, 0);
                check("ones_zero", Ones, 0);
            end
            if (m_valid) begin
                check("hund", Hund, m_mag / 100);
                check("tens", Tens, (m_mag / 10) % 10);
                check("ones", Ones, m_mag % 10);
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int n = 0;
        while (!In_Ready && n < 40) begin @(posedge Clk); #1; n++; end
        check("ready_wait", int'(n < 40), 1);
        In_Valid = 1'b1; In_Data = d;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!Out_Valid && n < 40) begin @(posedge Clk); #1; n++; end
        check("latency", n, 9);
    endtask

    task automatic expect_out(input string name, input int neg, input int mag,
                              input int h, input int t, input int o);
        check({name, "_valid"}, Out_Valid, 1);
        check({name, "_neg"}, Neg, neg);
        check({name, "_mag"}, Mag, mag);
        check({name, "_hund"}, Hund, h);
        check({name, "_tens"}, Tens, t);
        check({name, "_ones"}, Ones, o);
    endtask

    task automatic release_out();
        Out_Ready = 1'b1;
        @(posedge Clk); #1;
        Out_Ready = 1'b0;
        check("idle_after_done", In_Ready, 1);
        check("valid_after_done", Out_Valid, 0);
    endtask

    typedef struct { logic [7:0] d; int neg; int mag; int h; int t; int o; } vec_t;
    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'h80, 1, 128, 1, 2, 8};
        vecs[1] = '{8'h7F, 0, 127, 1, 2, 7};
        vecs[2] = '{8'hFF, 1,   1, 0, 0, 1};
        vecs[3] = '{8'h00, 0,   0, 0, 0, 0};
        vecs[4] = '{8'h9C, 1, 100, 1, 0, 0};
        vecs[5] = '{8'h63, 0,  99, 0, 9, 9};

        // Reset, including In_Valid asserted alongside Rst.
        repeat (2) @(posedge Clk);
        #1;
        check("rst_in_ready", In_Ready, 0);
        check("rst_out_valid", Out_Valid, 0);
        In_Valid = 1'b1; In_Data = 8'h55;
        @(posedge Clk); #1;
        check("rst_wins_mag", Mag, 0);
        check("rst_wins_ready", In_Ready, 0);
        In_Valid = 1'b0; Rst = 1'b0;
        @(posedge Clk); #1;
        check("ready_first_edge", In_Ready, 1);

        // Directed decode table.
        foreach (vecs[i]) begin
            send(vecs[i].d);
            wait_valid();
            expect_out($sformatf("vec%0d", i), vecs[i].neg, vecs[i].mag,
                       vecs[i].h, vecs[i].t, vecs[i].o);
            release_out();
        end

        // Backpressure on -42 with a competing input driven meanwhile.
        send(8'hD6);
        wait_valid();
        In_Valid = 1'b1; In_Data = 8'h11;
        repeat (5) begin
            @(posedge Clk); #1;
            check("bp_in_ready", In_Ready, 0);
            expect_out("bp", 1, 42, 0, 4, 2);
        end
        In_Valid = 1'b0;
        release_out();

        // Reset on the 4th CONV cycle.
        send(8'h37);
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        check("mid_rst_valid", Out_Valid, 0);
        check("mid_rst_ready", In_Ready, 0);
        check("mid_rst_neg", Neg, 0);
        check("mid_rst_mag", Mag, 0);
        check("mid_rst_digits", {Hund, Tens, Ones}, 0);
        Rst = 1'b0;
        @(posedge Clk); #1;
        check("post_rst_ready", In_Ready, 1);
        send(8'h05);
        wait_valid();
        expect_out("fresh5", 0, 5, 0, 0, 5);
        release_out();

        repeat (3) @(posedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
